// File: rtl/trace_pkg.sv
// Commit trace shared types: FSM states, capture modes
// and the stored trace entry.
package trace_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    POST  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } trace_state_e;

  typedef enum logic [1:0] {
    MODE_WRAP = 2'd0,
    MODE_FILL = 2'd1,
    MODE_TRIG = 2'd2
  } trace_mode_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } trace_entry_t;

  // The reserved encoding behaves as wrap.
  function automatic trace_mode_e decode_mode(
    input logic [1:0] m
  );
    unique case (m)
      2'd1:    return MODE_FILL;
      2'd2:    return MODE_TRIG;
      default: return MODE_WRAP;
    endcase
  endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Commit stream in, oldest-first readout out.
// master = core/host side, slave = trace buffer.
interface commit_trace_buffer_if
  import trace_pkg::*;
();

  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic [XLEN-1:0] commit_inst;
  logic            rd_valid;
  logic            rd_ready;
  logic [XLEN-1:0] rd_pc;
  logic [XLEN-1:0] rd_inst;
  logic            rd_last;

  modport master (
    output commit_valid,
    output commit_pc,
    output commit_inst,
    output rd_ready,
    input  rd_valid,
    input  rd_pc,
    input  rd_inst,
    input  rd_last
  );

  modport slave (
    input  commit_valid,
    input  commit_pc,
    input  commit_inst,
    input  rd_ready,
    output rd_valid,
    output rd_pc,
    output rd_inst,
    output rd_last
  );

endinterface

// File: rtl/trace_mem.sv
// Trace storage: one sync write port, one async read port.
// Storage is not reset; validity is tracked by the owner.
module trace_mem
  import trace_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  trace_entry_t wdata,
  input  logic [AW-1:0] raddr,
  output trace_entry_t rdata
);

  trace_entry_t mem [DEPTH];

  // Capture one entry per write strobe.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace capture FSM: wrap / fill / pc-trigger,
// then oldest-first drain over valid/ready.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter  int DEPTH  = 16,
  parameter  int POST_W = 8,
  localparam int AW     = $clog2(DEPTH),
  localparam int CW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [XLEN-1:0]   trig_pc,
  input  logic [POST_W-1:0] post_count,
  commit_trace_buffer_if.slave tif,
  output logic [2:0]        state,
  output logic [CW-1:0]     count,
  output logic              triggered,
  output logic              overflow
);

  trace_state_e      st;
  trace_mode_e       md;
  logic [XLEN-1:0]   trig_q;
  logic [POST_W-1:0] post_q;
  logic [POST_W-1:0] post_cnt;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic              trig_hit;
  logic              ovf;

  logic         capturing;
  logic         wr_en;
  logic         full;
  logic         hit;
  trace_entry_t wdata;
  trace_entry_t rdata;

  assign capturing = (st == ARMED) || (st == POST);
  assign wr_en     = capturing && tif.commit_valid;
  assign full      = (cnt == CW'(DEPTH));
  assign hit       = (md == MODE_TRIG) && (st == ARMED)
                  && (tif.commit_pc == trig_q);
  assign wdata     = '{pc: tif.commit_pc,
                       inst: tif.commit_inst};

  trace_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Capture/drain FSM with pointer and counter bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      md       <= MODE_WRAP;
      trig_q   <= '0;
      post_q   <= '0;
      post_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      trig_hit <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (arm) begin
            st       <= ARMED;
            md       <= decode_mode(mode);
            trig_q   <= trig_pc;
            post_q   <= post_count;
            cnt      <= '0;
            wr_ptr   <= '0;
            trig_hit <= 1'b0;
            ovf      <= 1'b0;
          end
        end
        ARMED, POST: begin
          if (tif.commit_valid) begin
            wr_ptr <= wr_ptr + AW'(1);
            if (full) ovf <= 1'b1;
            else      cnt <= cnt + CW'(1);
          end
          if (stop) begin
            st <= DONE;
          end else if (tif.commit_valid) begin
            if (md == MODE_FILL
                && cnt == CW'(DEPTH - 1)) begin
              st <= DONE;
            end else if (st == POST) begin
              post_cnt <= post_cnt - POST_W'(1);
              if (post_cnt == POST_W'(1)) st <= DONE;
            end else if (hit) begin
              trig_hit <= 1'b1;
              if (post_q == '0) begin
                st <= DONE;
              end else begin
                st       <= POST;
                post_cnt <= post_q;
              end
            end
          end
        end
        DONE: begin
          rd_ptr <= wr_ptr - AW'(cnt);
          st     <= (cnt == '0) ? IDLE : DRAIN;
        end
        DRAIN: begin
          if (tif.rd_ready) begin
            rd_ptr <= rd_ptr + AW'(1);
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) st <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign tif.rd_valid = (st == DRAIN);
  assign tif.rd_last  = (st == DRAIN) && (cnt == CW'(1));
  assign tif.rd_pc    = tif.rd_valid ? rdata.pc   : '0;
  assign tif.rd_inst  = tif.rd_valid ? rdata.inst : '0;

  assign state     = st;
  assign count     = cnt;
  assign triggered = trig_hit;
  assign overflow  = ovf;

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
Synthesizable on-chip commit trace for riscv32s, replacing ad-hoc bench-side instruction monitoring. It captures the retired-instruction stream (pc, instruction word) into a parametrised circular buffer. Three capture modes are supported: continuous wrap, fill-and-stop, and PC-triggered with post-trigger count. The captured window drains oldest-first over a valid/ready port. It sits beside riscvcore, fed from the core's commit strobe; readout goes to a debug host or a self-checking bench.

Parameters:
XLEN, 32, width of pc and instruction fields
DEPTH, 16, entries in the buffer; power of two, >=2
POST_W, 8, width of the post-trigger counter

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
arm  in  1  one-cycle pulse; starts capture from IDLE; ignored in any other state
stop  in  1  one-cycle pulse; forces capture to end (ARMED/POST -> DONE)
mode  in  2  capture mode, sampled at arm: 0 WRAP, 1 FILL, 2 TRIG, 3 reserved (treated as WRAP)
trig_pc  in  XLEN  trigger address, sampled at arm
post_count  in  POST_W  commits captured after the trigger entry, sampled at arm
commit_valid  in  1  core retired an instruction this cycle
commit_pc  in  XLEN  pc of the retired instruction
commit_inst  in  XLEN  instruction word
rd_valid  out  1  readout entry available
rd_ready  in  1  consumer accepts the entry
rd_pc  out  XLEN  pc of the oldest unread entry
rd_inst  out  XLEN  instruction of the oldest unread entry
rd_last  out  1  current entry is the final one
state  out  3  FSM state, encoded per package enum
count  out  $clog2(DEPTH)+1  valid entries held, 0..DEPTH
triggered  out  1  trigger fired during this capture
overflow  out  1  at least one entry was overwritten

Behaviour:
- Reset (async, any state): state=IDLE, wr_ptr=0, count=0, post counter=0, triggered=0, overflow=0, rd_valid=0, rd_last=0, rd_pc/rd_inst=0. Reset mid-capture or mid-drain discards all contents.
- IDLE: no capture. arm -> ARMED on the next edge; latch mode, trig_pc and post_count; clear count, wr_ptr, triggered and overflow.
- ARMED: each commit_valid cycle writes {commit_pc, commit_inst} at wr_ptr; wr_ptr increments mod DEPTH; count saturates at DEPTH.
  - WRAP/TRIG: writing while count==DEPTH overwrites the oldest entry and sets overflow (sticky until next arm).
  - FILL: the write that makes count==DEPTH also moves the state to DONE; no overwrite occurs; overflow stays 0.
  - TRIG: a commit with commit_pc==trig_pc is captured and sets triggered. If post_count==0 -> DONE; else -> POST with counter=post_count.
  - A trigger match in WRAP or FILL mode is ignored.
- POST: each commit is captured (wrap rules as ARMED) and decrements the counter. The commit that takes the counter to 0 is captured, then -> DONE.
- stop in ARMED/POST -> DONE. A commit arriving in the same cycle is still captured; stop wins over any further trigger evaluation.
- DONE: capture is frozen; commit_valid is ignored. rd_ptr = (wr_ptr - count) mod DEPTH.
  - If count==0 -> IDLE next cycle, rd_valid never asserts.
  - Else -> DRAIN.
- DRAIN:
  - rd_valid=1 while count>0; rd_pc/rd_inst show the entry at rd_ptr (combinational read); rd_last = (count==1).
  - On rd_valid&&rd_ready: rd_ptr++ mod DEPTH, count--.
  - The last accepted entry -> IDLE on the same edge.
  - Outputs hold stable while rd_valid && !rd_ready.
  - arm and stop are ignored in DRAIN.
- Throughput: one capture per cycle and one readout per cycle. Latency from commit to stored is one edge.

Decomposition:
- Package trace_pkg holds:
  - trace_state_e {IDLE, ARMED, POST, DONE, DRAIN}
  - trace_mode_e {MODE_WRAP, MODE_FILL, MODE_TRIG}
  - trace_entry_t struct {pc, inst}, parametrised via XLEN localparam
- Sub-module trace_mem: DEPTH x trace_entry_t flop array with one synchronous write port (no reset on storage) and one asynchronous read port.
- FSM, pointers and counters live in commit_trace_buffer.

Test Plan:
- Arm WRAP, 5 commits pc=0x00..0x40 step 0x10, stop -> drain 5 entries oldest-first pc 0x00..0x40; rd_last on 5th; overflow=0; state returns IDLE.
- Arm WRAP, DEPTH+3=19 commits pc=0x10*i, stop -> count=16, overflow=1, first drained pc=0x30, last pc=0x120.
- Arm FILL, 20 commits -> state DONE after 16th commit; drained pcs 0x000..0x0F0; commits 17-20 absent.
- Arm TRIG trig_pc=0x80 post_count=2, commits pc 0x00..0xF0 step 0x10 -> triggered=1; DONE after pc 0xA0; count=11; drained 0x00..0xA0.
- Backpressure: drain 4 entries with rd_ready toggling 1,0,0,1,... -> each entry is held unchanged while stalled; exactly 4 handshakes; no duplicates or drops.
- Assert reset during DRAIN with count=7 -> immediate IDLE, count=0, rd_valid=0. Next arm with zero commits then stop -> IDLE with rd_valid never high.
